dcache_wb_buffer: RTL

- Dirty-line write-back buffer between dcache and cache_AXI: accepts evicted 128-bit lines from dcache, queues them in a small FIFO and drains them one at a time over the cache_AXI dcache-write handshake (data_wen/data_awaddr/data_wdata/data_bvalid).
- Returns the newest queued copy to dcache when a refill hits a line still in the buffer, so dcache never reads stale memory.
- Lets dcache refill reads proceed without waiting for the eviction to finish.

---
 rtl/cache_pkg.sv | 13 +
 rtl/wb_match_unit.sv | 46 ++++
 rtl/dcache_wb_buffer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared cache constants and the write-back drain FSM state encoding.
package cache_pkg;

  localparam int LINE_W = 128;
  localparam int OFFS_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_match_unit.sv
// Age-ordered address CAM over the write-back entries; reports the youngest
// valid, non-excluded entry whose line tag equals query_tag.
module wb_match_unit #(
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 28,
  parameter int LINE_W = 128,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0]             excl,
  input  logic [DEPTH-1:0][TAG_W-1:0]  tags,
  input  logic [DEPTH-1:0][LINE_W-1:0] lines,
  input  logic [PTR_W-1:0]             wr_ptr,
  input  logic [TAG_W-1:0]             query_tag,
  output logic                         hit,
  output logic [PTR_W-1:0]             hit_idx,
  output logic [LINE_W-1:0]            hit_data
);

  logic [DEPTH-1:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
      assign match[gi] = valid[gi] && !excl[gi] && (tags[gi] == query_tag);
    end
  endgenerate

  // Visit slots oldest (wr_ptr) to youngest (wr_ptr-1); later hits override.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = wr_ptr - PTR_W'(k);
      if (match[idx]) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

  assign hit_data = hit ? lines[hit_idx] : '0;

endmodule

// File: rtl/dcache_wb_buffer.sv
// Dirty-line write-back FIFO between dcache and cache_AXI with refill lookup.
// Optional: define WB_COALESCE_EN to merge pushes into a queued, idle entry.
module dcache_wb_buffer #(
  parameter int DEPTH  = 4,
  parameter int LINE_W = cache_pkg::LINE_W,
  parameter int ADDR_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_valid,
  output logic                    wb_ready,
  input  logic [ADDR_W-1:0]       wb_addr,
  input  logic [LINE_W-1:0]       wb_data,
  input  logic [ADDR_W-1:0]       lkup_addr,
  output logic                    lkup_hit,
  output logic [LINE_W-1:0]       lkup_data,
  output logic                    data_wen_o,
  output logic [ADDR_W-1:0]       data_awaddr_o,
  output logic [LINE_W-1:0]       data_wdata_o,
  input  logic                    data_bvalid_i,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);

  import cache_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ADDR_W - OFFS_W;

  logic [DEPTH-1:0][TAG_W-1:0]  tag_mem;
  logic [DEPTH-1:0][LINE_W-1:0] data_mem;
  logic [DEPTH-1:0]             valid_reg;
  logic [PTR_W-1:0]             wr_ptr_reg;
  logic [PTR_W-1:0]             rd_ptr_reg;
  logic [CNT_W-1:0]             count_reg;
  wb_state_e                    state_reg;
  logic                         wen_reg;

  logic                         full;
  logic                         pop;
  logic                         push_alloc;
  logic                         push_coal;
  logic                         coal_hit;
  logic [PTR_W-1:0]             coal_idx;
  logic [PTR_W-1:0]             lkup_idx_unused;
  logic [2*OFFS_W-1:0]          offs_unused;

  assign offs_unused = {wb_addr[OFFS_W-1:0], lkup_addr[OFFS_W-1:0]};

  // Ready comes from the registered count, so a same-cycle pop cannot reopen it.
  assign full       = (count_reg == CNT_W'(DEPTH));
  assign wb_ready   = !full;
  assign pop        = (state_reg == SEND) && data_bvalid_i;
  assign push_coal  = wb_valid && coal_hit;
  assign push_alloc = wb_valid && !coal_hit && !full;

  wb_match_unit #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .LINE_W (LINE_W),
    .PTR_W  (PTR_W)
  ) u_lkup (
    .valid     (valid_reg),
    .excl      ({DEPTH{1'b0}}),
    .tags      (tag_mem),
    .lines     (data_mem),
    .wr_ptr    (wr_ptr_reg),
    .query_tag (lkup_addr[ADDR_W-1:OFFS_W]),
    .hit       (lkup_hit),
    .hit_idx   (lkup_idx_unused),
    .hit_data  (lkup_data)
  );

`ifdef WB_COALESCE_EN
  // The in-flight head must keep its data stable, so it never absorbs a push.
  logic [DEPTH-1:0]  head_excl;
  logic [LINE_W-1:0] coal_data_unused;

  assign head_excl = (state_reg == SEND) ? (DEPTH'(1) << rd_ptr_reg) : '0;

  wb_match_unit #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .LINE_W (LINE_W),
    .PTR_W  (PTR_W)
  ) u_coal (
    .valid     (valid_reg),
    .excl      (head_excl),
    .tags      (tag_mem),
    .lines     (data_mem),
    .wr_ptr    (wr_ptr_reg),
    .query_tag (wb_addr[ADDR_W-1:OFFS_W]),
    .hit       (coal_hit),
    .hit_idx   (coal_idx),
    .hit_data  (coal_data_unused)
  );
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
`endif

  // Entry storage carries no reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (push_alloc) begin
      tag_mem[wr_ptr_reg]  <= wb_addr[ADDR_W-1:OFFS_W];
      data_mem[wr_ptr_reg] <= wb_data;
    end else if (push_coal) begin
      data_mem[coal_idx] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      state_reg  <= IDLE;
      wen_reg    <= 1'b0;
    end else begin
      if (push_alloc) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + CNT_W'(push_alloc) - CNT_W'(pop);

      // Allocation never targets the popped slot: that would need a full buffer.
      for (int i = 0; i < DEPTH; i++) begin
        if (push_alloc && (wr_ptr_reg == PTR_W'(i))) begin
          valid_reg[i] <= 1'b1;
        end else if (pop && (rd_ptr_reg == PTR_W'(i))) begin
          valid_reg[i] <= 1'b0;
        end
      end

      case (state_reg)
        IDLE: begin
          if (count_reg != '0) begin
            state_reg <= SEND;
            wen_reg   <= 1'b1;
          end
        end
        SEND: begin
          if (data_bvalid_i) begin
            state_reg <= GAP;
            wen_reg   <= 1'b0;
          end
        end
        GAP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          wen_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign data_wen_o    = wen_reg;
  assign data_awaddr_o = {tag_mem[rd_ptr_reg], {OFFS_W{1'b0}}};
  assign data_wdata_o  = data_mem[rd_ptr_reg];
  assign empty         = (count_reg == '0) && (state_reg == IDLE);
  assign count         = count_reg;

`ifndef SYNTHESIS
  bvalid_only_in_send: assert property (@(posedge clk) disable iff (rst)
    data_bvalid_i |-> (state_reg == SEND));
`endif

endmodule
